tl_reg_slave: RTL and testbench
===============================

TL_REG_SLAVE -- requirements
Module: tl_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning A-channel and register address width.
REQ-002 SHALL have parameter SRC_W, default 2, meaning TileLink source-ID width.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning wait-cycle limit before an error response.
REQ-004 SHALL have port: clock, input, 1, sole clock, rising edge.
REQ-005 SHALL have port: reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have A-channel inputs from the upstream fragmenter: a_valid 1, a_opcode 3, a_param 3, a_size 2, a_source SRC_W, a_address ADDR_W, a_mask 4, a_data 32; and output a_ready 1.
REQ-007 SHALL have D-channel outputs: d_valid 1, d_opcode 3, d_param 2, d_size 2, d_source SRC_W, d_denied 1, d_data 32; and input d_ready 1.
REQ-008 SHALL have register-port outputs: rq_valid 1, rq_write 1, rq_addr ADDR_W, rq_wdata 32, rq_wmask 4; input rq_ready 1.
REQ-009 SHALL have register-port inputs: rs_valid 1, rs_rdata 32, rs_error 1.

Function
REQ-010 SHALL be a TL-UL single-beat slave with one transaction outstanding; FSM states IDLE, REQ, WAIT, RESP.
REQ-011 SHALL assert a_ready only in IDLE; an A fire captures opcode, size, source, address, mask, data.
REQ-012 SHALL, in IDLE on A fire, go to REQ when opcode is Get(4), PutFull(0) or PutPartial(1) and a_size<=2; otherwise go to RESP with denied=1 and no register access.
REQ-013 SHALL drive rq_valid=1 in REQ only, rq_write=(opcode!=4), rq_addr word-aligned (low 2 bits zero), rq_wmask=a_mask for Puts, 4'hF for Get.
REQ-014 SHALL move REQ->WAIT on rq_valid&&rq_ready; rq_* payload stable while rq_valid&&!rq_ready.
REQ-015 SHALL, in WAIT, capture rs_rdata and rs_error on rs_valid and go to RESP next cycle; rs_valid outside WAIT is ignored.
REQ-016 SHALL, in RESP, drive d_valid=1, d_opcode=1 (AccessAckData) for Get and for denied Get-class, else 0 (AccessAck), d_param=0, d_size and d_source echoing the request, d_denied=captured error, d_data=captured rdata for Get else 0.
REQ-017 SHALL hold D payload stable until d_ready; on d_valid&&d_ready return to IDLE, a_ready asserting the following cycle (minimum A-to-A spacing 4 cycles with zero-wait register).
REQ-018 SHALL give zero-wait latency: A fire at cycle N, rq_valid N+1, rs_valid N+2, d_valid N+3.
REQ-019 SHALL not combinationally depend d_valid or a_ready on d_ready or a_valid.

Reset
REQ-020 SHALL, while reset is low, force state IDLE, a_ready=0, d_valid=0, rq_valid=0, all captured payload and D outputs 0, timeout counter 0.
REQ-021 SHALL, on reset mid-transaction, abandon it with no D response; a_ready=1 the first cycle after reset deasserts.

Configuration
REQ-022 SHALL compile the WAIT timeout only when TL_REG_TIMEOUT_EN is defined.
REQ-023 SHALL, with TL_REG_TIMEOUT_EN, count WAIT cycles from 0 and, on reaching TIMEOUT without rs_valid, go to RESP with d_denied=1, d_data=0; rs_valid in the same cycle wins.
REQ-024 SHALL, without TL_REG_TIMEOUT_EN, wait in WAIT indefinitely and contain no counter logic.

Structure
REQ-025 SHALL place TL opcode constants (Get, PutFull, PutPartial, AccessAck, AccessAckData) and the state enum in package tl_reg_pkg.
REQ-026 SHALL implement the timeout counter as sub-module tl_reg_timeout, instantiated only under TL_REG_TIMEOUT_EN.

Verification
REQ-027 SHALL cover Get addr 0x104, source 2, size 2, zero-wait register returning 0xDEADBEEF -> d_valid at A+3, d_opcode 1, d_source 2, d_data 0xDEADBEEF, d_denied 0.
REQ-028 SHALL cover PutPartial addr 0x00A, mask 4'b1100, data 0x12345678 -> rq_addr 0x008, rq_wmask 4'b1100, rq_write 1; D opcode 0, d_data 0.
REQ-029 SHALL cover opcode 2 (Arithmetic) or a_size 3 -> no rq_valid, d_denied 1 one cycle after A fire.
REQ-030 SHALL cover rq_ready low 5 cycles and d_ready low 3 cycles -> rq and D payloads stable, a_ready 0 throughout.
REQ-031 SHALL cover, with TL_REG_TIMEOUT_EN and TIMEOUT=4, rs_valid never asserted -> d_denied 1 after 4 WAIT cycles; without the macro, no response.
REQ-032 SHALL cover reset asserted in WAIT -> all outputs 0 at once; a new Get after release completes normally.

Source files
------------

// File: rtl/tl_reg_pkg.sv
// Shared TileLink opcodes, FSM state type and request-classification helpers for tl_reg_slave.
package tl_reg_pkg;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_ARITH_DATA      = 3'd2;
  localparam logic [2:0] OP_LOGICAL_DATA    = 3'd3;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic is_legal(input logic [2:0] opcode, input logic [1:0] size);
    return ((opcode == OP_GET) || (opcode == OP_PUT_FULL) || (opcode == OP_PUT_PARTIAL))
           && (size <= 2'd2);
  endfunction

  // Requests whose TileLink response carries data (Get, ArithmeticData, LogicalData).
  function automatic logic returns_data(input logic [2:0] opcode);
    return (opcode == OP_GET) || (opcode == OP_ARITH_DATA) || (opcode == OP_LOGICAL_DATA);
  endfunction

endpackage

// File: rtl/tl_reg_timeout.sv
// WAIT-state watchdog for tl_reg_slave: flags expiry on the TIMEOUT-th consecutive WAIT cycle.
module tl_reg_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  assign expired = run && (count_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (!run) begin
      count_q <= '0;
    end else if (!expired) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/tl_reg_slave.sv
// TL-UL single-beat slave bridging one outstanding A request onto a simple register port.
// Define TL_REG_TIMEOUT_EN to answer with a denied response when the register port stalls TIMEOUT cycles.
module tl_reg_slave import tl_reg_pkg::*; #(
  parameter int ADDR_W  = 12,
  parameter int SRC_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [1:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_data,
  output logic              a_ready,
  output logic              d_valid,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [1:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_denied,
  output logic [31:0]       d_data,
  input  logic              d_ready,
  output logic              rq_valid,
  output logic              rq_write,
  output logic [ADDR_W-1:0] rq_addr,
  output logic [31:0]       rq_wdata,
  output logic [3:0]        rq_wmask,
  input  logic              rq_ready,
  input  logic              rs_valid,
  input  logic [31:0]       rs_rdata,
  input  logic              rs_error
);

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [1:0]          size_q;
  logic [SRC_W-1:0]    source_q;
  logic [ADDR_W-1:2]   addr_q;
  logic [3:0]          mask_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                denied_q;
  logic                timeout_hit;
  logic                unused_inputs;

`ifdef TL_REG_TIMEOUT_EN
  tl_reg_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .run     (state_q == ST_WAIT),
    .expired (timeout_hit)
  );
  assign unused_inputs = ^{a_param, a_address[1:0]};
`else
  assign timeout_hit   = 1'b0;
  assign unused_inputs = ^{a_param, a_address[1:0], 1'(TIMEOUT)};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (a_valid) state_d = is_legal(a_opcode, a_size) ? ST_REQ : ST_RESP;
      ST_REQ:  if (rq_ready) state_d = ST_WAIT;
      ST_WAIT: if (rs_valid || timeout_hit) state_d = ST_RESP;
      ST_RESP: if (d_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data is cleared on A fire so denied and timed-out responses return zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      size_q   <= '0;
      source_q <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      denied_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && a_valid) begin
        op_q     <= a_opcode;
        size_q   <= a_size;
        source_q <= a_source;
        addr_q   <= a_address[ADDR_W-1:2];
        mask_q   <= a_mask;
        wdata_q  <= a_data;
        rdata_q  <= '0;
        denied_q <= !is_legal(a_opcode, a_size);
      end
      if (state_q == ST_WAIT) begin
        if (rs_valid) begin
          rdata_q  <= rs_rdata;
          denied_q <= rs_error;
        end else if (timeout_hit) begin
          denied_q <= 1'b1;
        end
      end
    end
  end

  assign a_ready  = (state_q == ST_IDLE) && reset;

  assign rq_valid = (state_q == ST_REQ);
  assign rq_write = rq_valid && (op_q != OP_GET);
  assign rq_addr  = {addr_q, 2'b00};
  assign rq_wdata = wdata_q;
  assign rq_wmask = !rq_valid ? 4'h0 : ((op_q == OP_GET) ? 4'hF : mask_q);

  assign d_valid  = (state_q == ST_RESP);
  assign d_opcode = returns_data(op_q) ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
  assign d_param  = 2'd0;
  assign d_size   = size_q;
  assign d_source = source_q;
  assign d_denied = denied_q;
  assign d_data   = (op_q == OP_GET) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_tl_reg_slave.sv
// Self-checking bench for tl_reg_slave: directed scenarios plus randomized transactions
// scored against a transaction-level reference model.
module tb_tl_reg_slave;

  localparam int ADDR_W  = 12;
  localparam int SRC_W   = 2;
  localparam int TIMEOUT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [1:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [3:0]        a_mask;
  logic [31:0]       a_data;
  logic              a_ready;
  logic              d_valid;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [1:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic [31:0]       d_data;
  logic              d_ready;
  logic              rq_valid;
  logic              rq_write;
  logic [ADDR_W-1:0] rq_addr;
  logic [31:0]       rq_wdata;
  logic [3:0]        rq_wmask;
  logic              rq_ready;
  logic              rs_valid;
  logic [31:0]       rs_rdata;
  logic              rs_error;

  int n_cmp  = 0;
  int n_fail = 0;

  tl_reg_slave #(
    .ADDR_W  (ADDR_W),
    .SRC_W   (SRC_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_opcode  (a_opcode),
    .a_param   (a_param),
    .a_size    (a_size),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .d_valid   (d_valid),
    .d_opcode  (d_opcode),
    .d_param   (d_param),
    .d_size    (d_size),
    .d_source  (d_source),
    .d_denied  (d_denied),
    .d_data    (d_data),
    .d_ready   (d_ready),
    .rq_valid  (rq_valid),
    .rq_write  (rq_write),
    .rq_addr   (rq_addr),
    .rq_wdata  (rq_wdata),
    .rq_wmask  (rq_wmask),
    .rq_ready  (rq_ready),
    .rs_valid  (rs_valid),
    .rs_rdata  (rs_rdata),
    .rs_error  (rs_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic send_a(input logic [2:0] op, input logic [1:0] size, input logic [1:0] src,
                        input logic [11:0] addr, input logic [3:0] mask, input logic [31:0] data);
    check("a_ready_idle", a_ready, 1);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_param   = 3'($urandom_range(0, 7));
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    step();
    a_valid   = 1'b0;
    a_opcode  = 3'($urandom);
    a_size    = 2'($urandom);
    a_source  = 2'($urandom);
    a_address = 12'($urandom);
    a_mask    = 4'($urandom);
    a_data    = $urandom;
    check("a_ready_busy", a_ready, 0);
  endtask

  // Reference model: one full transaction, expectations derived from the TL-UL rules.
  task automatic do_txn(input logic [2:0] op, input logic [1:0] size, input logic [1:0] src,
                        input logic [11:0] addr, input logic [3:0] mask, input logic [31:0] data,
                        input int rq_delay, input int rs_delay, input logic [31:0] rdata,
                        input logic err, input int d_delay);
    bit          legal    = (op == 3'd0 || op == 3'd1 || op == 3'd4) && (size <= 2'd2);
    bit          is_get   = (op == 3'd4);
    logic [2:0]  exp_dop  = (op == 3'd2 || op == 3'd3 || op == 3'd4) ? 3'd1 : 3'd0;
    logic        exp_den  = legal ? err : 1'b1;
    logic [31:0] exp_data = (is_get && legal) ? rdata : 32'd0;
    logic [11:0] exp_addr = (addr / 12'd4) * 12'd4;
    send_a(op, size, src, addr, mask, data);
    if (legal) begin
      for (int i = 0; i <= rq_delay; i++) begin
        check("rq_valid", rq_valid, 1);
        check("rq_write", rq_write, !is_get);
        check("rq_addr", rq_addr, exp_addr);
        check("rq_wmask", rq_wmask, is_get ? 4'hF : mask);
        if (!is_get) check("rq_wdata", rq_wdata, data);
        check("d_valid_in_req", d_valid, 0);
        rq_ready = (i == rq_delay);
        rs_valid = 1'($urandom_range(0, 1));
        rs_rdata = $urandom;
        rs_error = 1'($urandom_range(0, 1));
        step();
      end
      rq_ready = 1'b0;
      check("rq_valid_after_fire", rq_valid, 0);
      for (int i = 0; i <= rs_delay; i++) begin
        check("d_valid_in_wait", d_valid, 0);
        rs_valid = (i == rs_delay);
        rs_rdata = (i == rs_delay) ? rdata : $urandom;
        rs_error = (i == rs_delay) ? err : 1'($urandom_range(0, 1));
        step();
      end
      rs_valid = 1'b0;
    end else begin
      check("rq_valid_denied", rq_valid, 0);
    end
    for (int i = 0; i <= d_delay; i++) begin
      check("d_valid", d_valid, 1);
      check("d_opcode", d_opcode, exp_dop);
      check("d_param", d_param, 0);
      check("d_size", d_size, size);
      check("d_source", d_source, src);
      check("d_denied", d_denied, exp_den);
      check("d_data", d_data, exp_data);
      check("a_ready_resp", a_ready, 0);
      check("rq_valid_resp", rq_valid, 0);
      d_ready = (i == d_delay);
      step();
    end
    d_ready = 1'b0;
    check("d_valid_done", d_valid, 0);
  endtask

  initial begin
    logic [2:0] op;
    int         pick;

    reset = 1'b0; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
    a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b0; rq_ready = 1'b0;
    rs_valid = 1'b0; rs_rdata = '0; rs_error = 1'b0;
    #1;
    check("reset_a_ready", a_ready, 0);
    check("reset_d_valid", d_valid, 0);
    check("reset_rq_valid", rq_valid, 0);
    check("reset_d_data", d_data, 0);
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("post_reset_a_ready", a_ready, 1);
    step();

    $display("[TB] zero-wait Get of 0x104");
    do_txn(3'd4, 2'd2, 2'd2, 12'h104, 4'hF, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 0);
    $display("[TB] PutPartial to 0x00A");
    do_txn(3'd1, 2'd2, 2'd1, 12'h00A, 4'b1100, 32'h12345678, 0, 0, 32'hCAFEF00D, 1'b0, 0);
    $display("[TB] illegal opcode and oversize Get");
    do_txn(3'd2, 2'd2, 2'd3, 12'h040, 4'hF, 32'h1, 0, 0, 32'h0, 1'b0, 0);
    do_txn(3'd4, 2'd3, 2'd0, 12'h080, 4'hF, 32'h2, 0, 0, 32'h0, 1'b0, 0);
    $display("[TB] back-pressure on register and D channels");
    do_txn(3'd0, 2'd2, 2'd1, 12'h3F4, 4'hF, 32'hA5A5_5A5A, 5, 1, 32'h0, 1'b0, 3);
    do_txn(3'd4, 2'd1, 2'd3, 12'h210, 4'h3, 32'h0, 5, 0, 32'h0BAD_F00D, 1'b1, 3);

    $display("[TB] register port never responds");
    send_a(3'd4, 2'd2, 2'd1, 12'h020, 4'hF, 32'h0);
    rq_ready = 1'b1;
    step();
    rq_ready = 1'b0;
`ifdef TL_REG_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT; i++) begin
      check("timeout_d_valid_early", d_valid, 0);
      step();
    end
    check("timeout_d_valid", d_valid, 1);
    check("timeout_d_denied", d_denied, 1);
    check("timeout_d_data", d_data, 0);
    check("timeout_d_opcode", d_opcode, 1);
    d_ready = 1'b1;
    step();
    d_ready = 1'b0;
`else
    for (int i = 0; i < 12; i++) begin
      check("no_timeout_d_valid", d_valid, 0);
      step();
    end
`endif

    $display("[TB] reset while waiting on the register port");
    if (!a_ready) begin
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
    end
    send_a(3'd4, 2'd2, 2'd2, 12'h104, 4'hF, 32'h0);
    rq_ready = 1'b1;
    step();
    rq_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_wait_a_ready", a_ready, 0);
    check("rst_wait_d_valid", d_valid, 0);
    check("rst_wait_rq_valid", rq_valid, 0);
    check("rst_wait_rq_write", rq_write, 0);
    check("rst_wait_d_source", d_source, 0);
    check("rst_wait_d_denied", d_denied, 0);
    step();
    reset = 1'b1;
    #1;
    check("rst_release_a_ready", a_ready, 1);
    check("rst_release_d_valid", d_valid, 0);
    step();
    do_txn(3'd4, 2'd2, 2'd1, 12'h0FC, 4'hF, 32'h0, 0, 0, 32'h1357_9BDF, 1'b0, 0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      pick = $urandom_range(0, 9);
      op   = (pick < 3) ? 3'd4 : (pick < 5) ? 3'd0 : (pick < 7) ? 3'd1 : 3'($urandom_range(2, 7));
      do_txn(op, 2'($urandom_range(0, 3)), 2'($urandom), 12'($urandom), 4'($urandom),
             $urandom, $urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1), $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
